arcade_input_conditioner: RTL and testbench
===========================================

// Module: arcade_input_conditioner
// PURPOSE
//  Conditions raw OSD joystick/coin levels before they are packed into the
//  core's INP0/INP1 input words. Synchronises and debounces every button.
//  Turns each coin press into one frame-timed pulse so the game CPU always
//  sees a legal coin-switch width, whatever the press length.
//  Sits between hps_io joystick outputs and the game-core input ports.
// PARAMETERS
//  NB            8    number of plain (non-coin) button/direction inputs
//  DEBOUNCE_CYC  1024 consecutive stable clk_sys cycles needed to accept a change (>=1)
//  COIN_PULSE_FR 3    coin_out high time, in vblank rising edges (>=1)
//  COIN_GAP_FR   3    forced low time after a pulse, in vblank rising edges (>=1)
// PORTS
//  clk_sys    in   1   system clock; all logic is on its rising edge
//  rst_n      in   1   asynchronous active-low reset
//  vblank     in   1   vertical blank level from the video timing generator (async; synced inside)
//  pause      in   1   1 = freeze frame counting (coin FSM holds state and outputs)
//  btn_raw    in   NB  raw button levels, active high
//  coin_raw   in   2   raw coin levels [0]=coin1 [1]=coin2, active high
//  btn_out    out  NB  debounced button levels
//  coin_out   out  2   shaped coin pulses, active high
//  coin_cnt   out  8   accepted-coin total, both slots, wraps 255->0
// BEHAVIOUR
//  Reset: btn_out=0, coin_out=0, coin_cnt=0, sync FFs=0, debounce counters=0,
//   both coin FSMs in IDLE, vblank edge detector history=0.
//  Sync: each of btn_raw, coin_raw, vblank goes through a 2-FF synchroniser.
//  Debounce, per bit, for btn and coin alike:
//   - counter clears on any cycle where sync==state.
//   - else it increments. When it is at DEBOUNCE_CYC-1 and sync!=state,
//     state takes sync on the next edge and the counter clears.
//   - latency from a raw edge held stable to btn_out toggle: exactly 2+DEBOUNCE_CYC cycles.
//   - a glitch shorter than DEBOUNCE_CYC synced cycles never reaches the output.
//  Frame tick: one-cycle strobe on the synced vblank 0->1 edge.
//   The strobe is masked while pause=1, so edges during pause are lost, not queued.
//  Coin FSM, one per slot, independent; both may fire on the same cycle:
//   IDLE    coin_out=0. On a debounced coin 0->1 edge: -> PULSE, with
//           coin_out=1 from the next cycle and coin_cnt+1.
//   PULSE   coin_out=1. Counts ticks; on the COIN_PULSE_FR-th tick, coin_out=0 -> GAP.
//           Release and re-press during PULSE are ignored.
//   GAP     coin_out=0. On the COIN_GAP_FR-th tick: -> WAIT_REL if debounced
//           coin is still 1, else -> IDLE.
//   WAIT_REL coin_out=0. -> IDLE when debounced coin==0. A held coin therefore
//           gives exactly one pulse.
//  Tick counter: 0 at state entry; its width is clog2 of the larger frame parameter, plus 1.
//  Simultaneous acceptance on both slots in one cycle: coin_cnt += 2, mod 256.
//  Tick arriving on the entry cycle of PULSE/GAP: not counted (counting starts next cycle).
//  Asynchronous rst_n assertion mid-pulse: coin_out drops immediately and the
//   FSM restarts in IDLE. A coin still held after release must be released
//   and pressed again before it is accepted.
//  Pause does not affect the debouncers or btn_out.
// TESTING
//  1 DEBOUNCE_CYC=16, btn_raw[0] high for 10 cycles then low -> btn_out[0] stays 0 throughout.
//  2 btn_raw[3] rises and holds -> btn_out[3]=1 exactly 18 cycles later; falls -> 0 after 18 more.
//  3 coin_raw[0] held for 20 frames -> exactly one coin_out[0] pulse of 3 ticks,
//    coin_cnt 0->1, no second pulse until release plus a new press.
//  4 pause=1 after the 1st tick of a pulse, for 5 vblank edges, then pause=0 ->
//    coin_out[0] stays high through the pause and falls on the 2nd later unpaused tick.
//  5 coin1 and coin2 accepted on the same cycle -> both pulse together; coin_cnt steps 254->0.
//  6 rst_n low mid-PULSE -> coin_out=0 asynchronously, coin_cnt=0; coin still held
//    after release -> no pulse until re-pressed.

Source files
------------

// File: rtl/arcade_input_if.sv
// Bundle of raw OSD joystick/coin levels and their conditioned counterparts.
// master drives the raw levels; slave is the conditioner.
interface arcade_input_if #(
  parameter int NB = 8
);
  logic          vblank;
  logic          pause;
  logic [NB-1:0] btn_raw;
  logic [1:0]    coin_raw;
  logic [NB-1:0] btn_out;
  logic [1:0]    coin_out;
  logic [7:0]    coin_cnt;

  modport master (
    output vblank, pause, btn_raw, coin_raw,
    input  btn_out, coin_out, coin_cnt
  );

  modport slave (
    input  vblank, pause, btn_raw, coin_raw,
    output btn_out, coin_out, coin_cnt
  );
endinterface

// File: rtl/arcade_input_conditioner.sv
// Synchronises and debounces joystick/coin levels; shapes each accepted coin
// into a single frame-timed pulse and keeps a running coin total.
module arcade_input_conditioner #(
  parameter int NB            = 8,
  parameter int DEBOUNCE_CYC  = 1024,
  parameter int COIN_PULSE_FR = 3,
  parameter int COIN_GAP_FR   = 3
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  arcade_input_if.slave bus
);

  localparam int NI   = NB + 2;
  localparam int DW   = $clog2(DEBOUNCE_CYC) + 1;
  localparam int FMAX = (COIN_PULSE_FR > COIN_GAP_FR) ? COIN_PULSE_FR : COIN_GAP_FR;
  localparam int TW   = $clog2(FMAX) + 1;

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(COIN_PULSE_FR - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(COIN_GAP_FR - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    GAP      = 2'd2,
    WAIT_REL = 2'd3
  } coin_state_t;

  logic [NI-1:0] raw_all;
  logic [NI-1:0] meta_reg;
  logic [NI-1:0] sync_reg;
  logic [NI-1:0] db_all;
  logic          vb_meta_reg;
  logic          vb_sync_reg;
  logic          vb_prev_reg;
  logic          tick;
  logic [1:0]    prime_reg;
  logic [1:0]    coin_db;
  logic [1:0]    coin_sync;
  logic [1:0]    accept;
  logic [1:0]    coin_pulse;
  logic [7:0]    coin_cnt_reg;
  logic [7:0]    coin_cnt_next;

  assign raw_all = {bus.coin_raw, bus.btn_raw};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg    <= '0;
      sync_reg    <= '0;
      vb_meta_reg <= 1'b0;
      vb_sync_reg <= 1'b0;
      vb_prev_reg <= 1'b0;
      prime_reg   <= 2'b00;
    end else begin
      meta_reg    <= raw_all;
      sync_reg    <= meta_reg;
      vb_meta_reg <= bus.vblank;
      vb_sync_reg <= vb_meta_reg;
      vb_prev_reg <= vb_sync_reg;
      prime_reg   <= {prime_reg[0], 1'b1};
    end
  end

  // Paused frames are dropped outright rather than queued.
  assign tick = vb_sync_reg & ~vb_prev_reg & ~bus.pause;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_db
      logic [DW-1:0] cnt_reg;
      logic          state_reg;

      always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg   <= '0;
          state_reg <= 1'b0;
        end else if (sync_reg[gi] == state_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_LAST) begin
          state_reg <= sync_reg[gi];
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign db_all[gi] = state_reg;
    end
  endgenerate

  assign coin_db   = db_all[NB+1:NB];
  assign coin_sync = sync_reg[NB+1:NB];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_coin
      coin_state_t   state_reg;
      coin_state_t   state_next;
      logic [TW-1:0] tick_reg;
      logic [TW-1:0] tick_next;
      logic          prev_reg;
      logic          armed_reg;
      logic          armed_next;
      logic          accept_bit;

      always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          tick_reg  <= '0;
          prev_reg  <= 1'b0;
          armed_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          tick_reg  <= tick_next;
          prev_reg  <= coin_db[gi];
          armed_reg <= armed_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        accept_bit = 1'b0;
        // A slot arms only once the live (synchronised) coin has been seen low,
        // so a coin held through reset never counts until it is re-pressed.
        armed_next = armed_reg | (prime_reg[1] & ~coin_sync[gi] & ~coin_db[gi]);
        case (state_reg)
          IDLE: begin
            if (armed_reg && coin_db[gi] && !prev_reg) begin
              accept_bit = 1'b1;
              state_next = PULSE;
              tick_next  = '0;
            end
          end
          PULSE: begin
            if (tick) begin
              if (tick_reg == PULSE_LAST) begin
                state_next = GAP;
                tick_next  = '0;
              end else begin
                tick_next = tick_reg + 1'b1;
              end
            end
          end
          GAP: begin
            if (tick) begin
              if (tick_reg == GAP_LAST) begin
                state_next = coin_db[gi] ? WAIT_REL : IDLE;
                tick_next  = '0;
              end else begin
                tick_next = tick_reg + 1'b1;
              end
            end
          end
          WAIT_REL: begin
            if (!coin_db[gi]) begin
              state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end

      assign accept[gi]     = accept_bit;
      assign coin_pulse[gi] = (state_reg == PULSE);
    end
  endgenerate

  assign coin_cnt_next = coin_cnt_reg + {7'd0, accept[0]} + {7'd0, accept[1]};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      coin_cnt_reg <= 8'd0;
    end else begin
      coin_cnt_reg <= coin_cnt_next;
    end
  end

  assign bus.btn_out  = db_all[NB-1:0];
  assign bus.coin_out = coin_pulse;
  assign bus.coin_cnt = coin_cnt_reg;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Directed bench for arcade_input_conditioner: table-driven debounce vectors
// followed by hand-written coin FSM sequences.
module tb_arcade_input_conditioner;

  localparam int NB  = 8;
  localparam int DB  = 16;
  localparam int LAT = DB + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arcade_input_if #(.NB(NB)) bus ();

  arcade_input_conditioner #(
    .NB(NB),
    .DEBOUNCE_CYC(DB),
    .COIN_PULSE_FR(3),
    .COIN_GAP_FR(3)
  ) dut (
    .clk_sys(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_tick();
    bus.vblank = 1'b1;
    step(4);
    bus.vblank = 1'b0;
    step(4);
  endtask

  typedef struct {
    int bit_idx;
    int high_cyc;
    int rise_at;
    int fall_at;
  } db_vec_t;

  db_vec_t vecs[6];
  int      exp_cnt;

  initial begin
    int          idx;
    int          rise_c;
    int          fall_c;
    logic        other_bad;
    logic [NB-1:0] mask;

    vecs[0] = '{0, 10, -1, -1};
    vecs[1] = '{0, 15, -1, -1};
    vecs[2] = '{1, 16, LAT, 16 + LAT};
    vecs[3] = '{3, 30, LAT, 30 + LAT};
    vecs[4] = '{7, 22, LAT, 22 + LAT};
    vecs[5] = '{5, 1, -1, -1};

    bus.vblank   = 1'b0;
    bus.pause    = 1'b0;
    bus.btn_raw  = '0;
    bus.coin_raw = 2'b00;
    rst_n        = 1'b0;
    step(3);
    check("rst_btn_out", 32'(bus.btn_out), 0);
    check("rst_coin_out", 32'(bus.coin_out), 0);
    check("rst_coin_cnt", 32'(bus.coin_cnt), 0);
    rst_n = 1'b1;
    step(4);

    // Debounce table: glitches never pass, held levels toggle after LAT cycles.
    for (int v = 0; v < 6; v++) begin
      idx       = vecs[v].bit_idx;
      rise_c    = -1;
      fall_c    = -1;
      other_bad = 1'b0;
      mask      = '1;
      mask[idx] = 1'b0;
      bus.btn_raw[idx] = 1'b1;
      for (int c = 1; c <= vecs[v].high_cyc + LAT + 4; c++) begin
        @(posedge clk);
        #1;
        if (bus.btn_out[idx] && rise_c < 0) rise_c = c;
        if (!bus.btn_out[idx] && rise_c >= 0 && fall_c < 0) fall_c = c;
        if ((bus.btn_out & mask) != '0) other_bad = 1'b1;
        if (c == vecs[v].high_cyc) bus.btn_raw[idx] = 1'b0;
      end
      check($sformatf("db%0d_rise_cycle", v), 32'(rise_c), 32'(vecs[v].rise_at));
      check($sformatf("db%0d_fall_cycle", v), 32'(fall_c), 32'(vecs[v].fall_at));
      check($sformatf("db%0d_other_bits", v), 32'(other_bad), 0);
    end

    // Short coin glitch is filtered.
    bus.coin_raw[0] = 1'b1;
    step(10);
    bus.coin_raw[0] = 1'b0;
    step(30);
    check("coin_glitch_out", 32'(bus.coin_out), 0);
    check("coin_glitch_cnt", 32'(bus.coin_cnt), 0);

    // Held coin: one 3-tick pulse only.
    bus.coin_raw[0] = 1'b1;
    step(20);
    check("hold_pulse_start", 32'(bus.coin_out), 1);
    check("hold_cnt", 32'(bus.coin_cnt), 1);
    for (int k = 1; k <= 20; k++) begin
      frame_tick();
      check($sformatf("hold_tick%0d", k), 32'(bus.coin_out[0]), (k < 3) ? 1 : 0);
    end
    check("hold_cnt_after", 32'(bus.coin_cnt), 1);
    bus.coin_raw[0] = 1'b0;
    step(25);
    check("release_out", 32'(bus.coin_out), 0);
    bus.coin_raw[0] = 1'b1;
    step(20);
    check("repress_out", 32'(bus.coin_out), 1);
    check("repress_cnt", 32'(bus.coin_cnt), 2);
    bus.coin_raw[0] = 1'b0;
    repeat (6) frame_tick();
    check("repress_done", 32'(bus.coin_out), 0);

    // Pause freezes the pulse.
    bus.coin_raw[0] = 1'b1;
    step(20);
    check("pause_start", 32'(bus.coin_out), 1);
    check("pause_cnt", 32'(bus.coin_cnt), 3);
    bus.coin_raw[0] = 1'b0;
    frame_tick();
    check("pause_tick1", 32'(bus.coin_out), 1);
    bus.pause = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      frame_tick();
      check($sformatf("paused_edge%0d", k), 32'(bus.coin_out), 1);
    end
    bus.pause = 1'b0;
    frame_tick();
    check("unpaused_tick1", 32'(bus.coin_out), 1);
    frame_tick();
    check("unpaused_tick2", 32'(bus.coin_out), 0);
    repeat (3) frame_tick();

    // Slot 2 alone, then paired presses up to the wrap.
    bus.coin_raw[1] = 1'b1;
    step(20);
    check("slot2_out", 32'(bus.coin_out), 2);
    check("slot2_cnt", 32'(bus.coin_cnt), 4);
    bus.coin_raw[1] = 1'b0;
    repeat (6) frame_tick();
    exp_cnt = 4;
    for (int i = 0; i < 125; i++) begin
      bus.coin_raw = 2'b11;
      step(20);
      exp_cnt = (exp_cnt + 2) % 256;
      bus.coin_raw = 2'b00;
      repeat (6) frame_tick();
    end
    check("pair_cnt_254", 32'(bus.coin_cnt), 32'(exp_cnt));
    bus.coin_raw = 2'b11;
    step(20);
    check("pair_both_out", 32'(bus.coin_out), 3);
    check("pair_wrap_cnt", 32'(bus.coin_cnt), 0);

    // Asynchronous reset mid-pulse with coins still held.
    frame_tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(bus.coin_out), 0);
    check("async_rst_cnt", 32'(bus.coin_cnt), 0);
    step(3);
    rst_n = 1'b1;
    step(40);
    check("held_after_rst_out", 32'(bus.coin_out), 0);
    repeat (6) frame_tick();
    check("held_after_ticks_out", 32'(bus.coin_out), 0);
    check("held_after_ticks_cnt", 32'(bus.coin_cnt), 0);
    bus.coin_raw = 2'b00;
    step(25);
    bus.coin_raw = 2'b11;
    step(20);
    check("rearm_out", 32'(bus.coin_out), 3);
    check("rearm_cnt", 32'(bus.coin_cnt), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
